// File: rtl/fifo_rd_packer_if.sv
// Bundle for the packer: FIFO read side (empty/rdata/error/rd_en), flush, and the packed output handshake.
// master = the packer; out_partial_o exists only when PACK_TIMEOUT_EN is defined.
interface fifo_rd_packer_if #(
  parameter int WIDTH      = 4,
  parameter int PACK_RATIO = 4
);
  localparam int OUT_WIDTH = WIDTH * PACK_RATIO;
  localparam int FILL_W    = $clog2(PACK_RATIO + 1);

  logic                 empty_i;
  logic [WIDTH-1:0]     rdata_i;
  logic                 error_i;
  logic                 rd_en_o;
  logic                 flush_i;
  logic [OUT_WIDTH-1:0] out_data_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [FILL_W-1:0]    out_fill_o;
  logic                 err_o;
`ifdef PACK_TIMEOUT_EN
  logic                 out_partial_o;
`endif

  modport master (
    input  empty_i, rdata_i, error_i, flush_i, out_ready_i,
    output rd_en_o, out_data_o, out_valid_o, out_fill_o,
`ifdef PACK_TIMEOUT_EN
    output out_partial_o,
`endif
    output err_o
  );

  modport slave (
    output empty_i, rdata_i, error_i, flush_i, out_ready_i,
    input  rd_en_o, out_data_o, out_valid_o, out_fill_o,
`ifdef PACK_TIMEOUT_EN
    input  out_partial_o,
`endif
    input  err_o
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops a 1-cycle-latency FIFO and packs PACK_RATIO entries LSB-first into one word on valid/ready; valid holds until accepted,
// pops stall while the word waits (a pop in the accept cycle refills slot 0). PACK_TIMEOUT_EN adds forced emission of idle partial words.
module fifo_rd_packer #(
  parameter int WIDTH      = 4,
  parameter int PACK_RATIO = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fifo_rd_packer_if.master  bus
);
  localparam int OUT_WIDTH = WIDTH * PACK_RATIO;
  localparam int FILL_W    = $clog2(PACK_RATIO + 1);

  logic [FILL_W-1:0]    cnt_q, cnt_d;
  logic                 inflight_q, inflight_d;
  logic [OUT_WIDTH-1:0] word_q, word_d;
  logic                 out_valid_q, out_valid_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 cap;
  logic                 fill_st;
  logic                 to_fire;
  logic                 rd_en;
  logic [FILL_W:0]      pend;

`ifdef PACK_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic                 partial_q, partial_d;
`endif

  always_comb begin
    accept  = out_valid_q && bus.out_ready_i;
    cap     = inflight_q && !bus.flush_i;
    fill_st = !out_valid_q && (cnt_q != '0);
    pend    = {1'b0, cnt_q} + {{FILL_W{1'b0}}, inflight_q};
`ifdef PACK_TIMEOUT_EN
    to_fire = fill_st && !inflight_q && !bus.flush_i && (idle_q == IDLE_W'(TIMEOUT - 1));
`else
    to_fire = 1'b0;
`endif
    // Timeout cycle also blocks the pop so no entry can land in a forced-out word.
    rd_en = !rst_i && !bus.flush_i && !bus.empty_i &&
            ((!out_valid_q && (pend < (FILL_W+1)'(PACK_RATIO)) && !to_fire) || accept);

    inflight_d  = rd_en;
    cnt_d       = cnt_q;
    word_d      = word_q;
    out_valid_d = out_valid_q;
    err_d       = err_q | bus.error_i;
`ifdef PACK_TIMEOUT_EN
    partial_d   = partial_q;
    idle_d      = '0;
    if (fill_st && !cap && !bus.flush_i && !to_fire)
      idle_d = idle_q + IDLE_W'(1);
`endif

    if (accept) begin
      out_valid_d = 1'b0;
      cnt_d       = '0;
      word_d      = '0;
`ifdef PACK_TIMEOUT_EN
      partial_d   = 1'b0;
`endif
    end

    // A waiting output word survives a flush; only accumulation is cleared.
    if (bus.flush_i && !out_valid_q) begin
      cnt_d  = '0;
      word_d = '0;
    end

    if (cap) begin
      for (int k = 0; k < PACK_RATIO; k++) begin
        if (cnt_d == FILL_W'(k))
          word_d[k*WIDTH +: WIDTH] = bus.rdata_i;
      end
      cnt_d = cnt_d + FILL_W'(1);
      if (cnt_d == FILL_W'(PACK_RATIO))
        out_valid_d = 1'b1;
    end

`ifdef PACK_TIMEOUT_EN
    if (to_fire) begin
      out_valid_d = 1'b1;
      partial_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef PACK_TIMEOUT_EN
      idle_q      <= '0;
      partial_q   <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
`ifdef PACK_TIMEOUT_EN
      idle_q      <= idle_d;
      partial_q   <= partial_d;
`endif
    end
  end

  assign bus.rd_en_o     = rd_en;
  assign bus.out_data_o  = word_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_fill_o  = cnt_q;
  assign bus.err_o       = err_q;
`ifdef PACK_TIMEOUT_EN
  assign bus.out_partial_o = partial_q;
`endif
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a queue-backed FIFO model of read latency 1.
module tb_fifo_rd_packer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_packer_if #(.WIDTH(4), .PACK_RATIO(4)) bus ();

  fifo_rd_packer #(.WIDTH(4), .PACK_RATIO(4), .TIMEOUT(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int          nvec = 0;
  int          nmis = 0;
  int          pops = 0;
  int          gate_viol = 0;
  logic [3:0]  fifo_q[$];
  logic        hold_empty = 1'b0;
  logic        found;
  logic [15:0] got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_empty();
    bus.empty_i = (fifo_q.size() == 0) || hold_empty;
  endtask

  task automatic push(input logic [3:0] v);
    fifo_q.push_back(v);
    upd_empty();
  endtask

  // One clock: sample rd_en mid-cycle, then return read data one cycle after the pop.
  task automatic tick();
    logic took;
    @(negedge clk);
    took = bus.rd_en_o;
    if (took) begin
      pops++;
      if (bus.empty_i) gate_viol++;
    end
    @(posedge clk);
    #1;
    if (took && fifo_q.size() != 0) bus.rdata_i = fifo_q.pop_front();
    upd_empty();
  endtask

  initial begin
    rst             = 1'b1;
    bus.empty_i     = 1'b1;
    bus.rdata_i     = '0;
    bus.error_i     = 1'b0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_valid", bus.out_valid_o, 0);
    chk("rst_data",  bus.out_data_o,  0);
    chk("rst_fill",  bus.out_fill_o,  0);
    chk("rst_err",   bus.err_o,       0);
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    #2;
    chk("rst_rden_gated", bus.rd_en_o, 0);

    // Basic pack
    rst  = 1'b0;
    pops = 0;
    repeat (4) tick();
    chk("basic_pre_valid", bus.out_valid_o, 0);
    chk("basic_pre_fill",  bus.out_fill_o,  3);
    tick();
    chk("basic_valid", bus.out_valid_o, 1);
    chk("basic_data",  bus.out_data_o,  16'h4321);
    chk("basic_fill",  bus.out_fill_o,  4);
    tick();
    chk("basic_post_valid", bus.out_valid_o, 0);
    chk("basic_post_fill",  bus.out_fill_o,  0);
    chk("basic_post_data",  bus.out_data_o,  0);
    chk("basic_pops",       pops,            4);

    // Back-pressure
    bus.out_ready_i = 1'b0;
    pops = 0;
    for (int v = 1; v <= 8; v++) push(4'(v));
    repeat (5) tick();
    chk("bp_valid", bus.out_valid_o, 1);
    chk("bp_data",  bus.out_data_o,  16'h4321);
    repeat (10) tick();
    chk("bp_hold_valid", bus.out_valid_o, 1);
    chk("bp_hold_data",  bus.out_data_o,  16'h4321);
    chk("bp_pops",       pops,            4);
    #1;
    chk("bp_rden_stall", bus.rd_en_o, 0);
    bus.out_ready_i = 1'b1;
    #1;
    chk("bp_accept_pop", bus.rd_en_o, 1);
    tick();
    chk("bp_acc_valid", bus.out_valid_o, 0);
    chk("bp_acc_fill",  bus.out_fill_o,  0);
    repeat (4) tick();
    chk("bp2_valid", bus.out_valid_o, 1);
    chk("bp2_data",  bus.out_data_o,  16'h8765);
    chk("bp2_fill",  bus.out_fill_o,  4);
    chk("bp2_pops",  pops,            8);
    tick();
    chk("bp2_post_valid", bus.out_valid_o, 0);

    // Sparse empty
    pops = 0;
    gate_viol = 0;
    push(4'hA); push(4'hB); push(4'hC); push(4'hD);
    found = 1'b0;
    got = '0;
    for (int i = 0; i < 40 && !found; i++) begin
      hold_empty = (i % 2 == 1);
      upd_empty();
      tick();
      if (bus.out_valid_o) begin
        found = 1'b1;
        got   = bus.out_data_o;
      end
    end
    hold_empty = 1'b0;
    upd_empty();
    chk("sparse_found", found,     1);
    chk("sparse_data",  got,       16'hDCBA);
    chk("sparse_pops",  pops,      4);
    chk("sparse_gate",  gate_viol, 0);
    tick();
    chk("sparse_post_valid", bus.out_valid_o, 0);

    // Flush mid-word with an entry in flight
    push(4'h5); push(4'h6); push(4'h7);
    repeat (3) tick();
    chk("flush_pre_fill", bus.out_fill_o, 2);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("flush_fill",  bus.out_fill_o,  0);
    chk("flush_data",  bus.out_data_o,  0);
    chk("flush_valid", bus.out_valid_o, 0);
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    repeat (5) tick();
    chk("flush_word_valid", bus.out_valid_o, 1);
    chk("flush_word_data",  bus.out_data_o,  16'h4321);
    tick();

    // Flush while a full word waits
    bus.out_ready_i = 1'b0;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    repeat (5) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("flushfull_valid", bus.out_valid_o, 1);
    chk("flushfull_data",  bus.out_data_o,  16'h4321);
    chk("flushfull_fill",  bus.out_fill_o,  4);
    bus.out_ready_i = 1'b1;
    tick();
    chk("flushfull_acc", bus.out_valid_o, 0);

    // Sticky error, then reset with cnt=3 and an entry in flight
    bus.error_i = 1'b1;
    tick();
    bus.error_i = 1'b0;
    chk("err_set", bus.err_o, 1);
    tick();
    chk("err_sticky", bus.err_o, 1);
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    repeat (4) tick();
    chk("rst2_pre_fill", bus.out_fill_o, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_valid", bus.out_valid_o, 0);
    chk("rst2_fill",  bus.out_fill_o,  0);
    chk("rst2_data",  bus.out_data_o,  0);
    chk("rst2_err",   bus.err_o,       0);
    tick();
    chk("rst2_dropped", bus.out_fill_o, 0);
    push(4'h9); push(4'hA); push(4'hB); push(4'hC);
    repeat (5) tick();
    chk("rst2_word_valid", bus.out_valid_o, 1);
    chk("rst2_word_data",  bus.out_data_o,  16'hCBA9);
    tick();

    // Partial word after the FIFO goes empty
    push(4'h7); push(4'h9);
    repeat (3) tick();
    chk("part_fill", bus.out_fill_o, 2);
`ifdef PACK_TIMEOUT_EN
    repeat (15) tick();
    chk("to_early_valid", bus.out_valid_o, 0);
    tick();
    chk("to_valid",   bus.out_valid_o,   1);
    chk("to_partial", bus.out_partial_o, 1);
    chk("to_data",    bus.out_data_o,    16'h0097);
    chk("to_fill",    bus.out_fill_o,    2);
    tick();
    chk("to_acc_valid",   bus.out_valid_o,   0);
    chk("to_acc_partial", bus.out_partial_o, 0);
    chk("to_acc_fill",    bus.out_fill_o,    0);
`else
    repeat (30) tick();
    chk("part_hold_valid", bus.out_valid_o, 0);
    chk("part_hold_fill",  bus.out_fill_o,  2);
    chk("part_hold_data",  bus.out_data_o,  16'h0097);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("part_flush_fill", bus.out_fill_o, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
